// File: rtl/instr_enc_pkg.sv
// Shared types, opcode constants and packing helpers for the RV64 instruction encoder.
// RANGE_CHECK_EN adds the immediate range-check helper.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_OPIMM  = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_JAL    = 7'd111;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm;
  } enc_fields_t;

  function automatic logic [31:0] pack_instr(input enc_fields_t f);
    logic [31:0] w;
    w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    case (f.fmt)
      FMT_R:  w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
      FMT_I:  w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
      FMT_S:  w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
      FMT_SB: w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                   f.imm[4:1], f.imm[11], f.opcode};
      FMT_U:  w = {f.imm[31:12], f.rd, f.opcode};
      FMT_UJ: w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
      default: w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    endcase
    return w;
  endfunction

`ifdef RANGE_CHECK_EN
  // A signed value fits in N bits when every bit from N-1 upward is a copy of the sign.
  function automatic logic imm_out_of_range(input enc_fields_t f);
    logic e;
    e = 1'b1;
    case (f.fmt)
      FMT_R:         e = 1'b0;
      FMT_I, FMT_S:  e = ~((&f.imm[63:11]) | ~(|f.imm[63:11]));
      FMT_SB:        e = ~((&f.imm[63:12]) | ~(|f.imm[63:12])) | f.imm[0];
      FMT_UJ:        e = ~((&f.imm[63:20]) | ~(|f.imm[63:20])) | f.imm[0];
      FMT_U:         e = (|f.imm[11:0]) | ~((&f.imm[63:31]) | ~(|f.imm[63:31]));
      default:       e = 1'b1;
    endcase
    return e;
  endfunction
`endif

endpackage

// File: rtl/instr_enc_skid.sv
// Generic 2-entry valid/ready buffer: output register plus one skid entry.
// in_ready comes straight from a flop, so it never depends on out_ready combinationally.
module instr_enc_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         push_s, pop_s;

  always_comb begin
    push_s       = in_valid & ~skid_valid_q;
    pop_s        = out_valid_q & out_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (skid_valid_q) begin
      if (pop_s) begin
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else if (out_valid_q) begin
      // One entry held: a simultaneous push and pop replaces it in place.
      if (pop_s && push_s) begin
        out_data_d = in_data;
      end else if (pop_s) begin
        out_valid_d = 1'b0;
      end else if (push_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
      end else begin
        out_valid_d = 1'b1;
      end
    end else begin
      if (push_s) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded fields plus immediate into a 32-bit RV64 instruction word, buffered on a valid/ready stream.
// Define RANGE_CHECK_EN to flag out-of-range immediates on out_err.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int IMM_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [IMM_W-1:0] in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count
);

  enc_fields_t      fields_s;
  logic [31:0]      instr_s;
  logic             err_s;
  logic [32:0]      out_data_s;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  always_comb begin
    fields_s.fmt    = in_fmt;
    fields_s.opcode = in_opcode;
    fields_s.rd     = in_rd;
    fields_s.rs1    = in_rs1;
    fields_s.rs2    = in_rs2;
    fields_s.funct3 = in_funct3;
    fields_s.funct7 = in_funct7;
    fields_s.imm    = 64'($signed(in_imm));
    instr_s         = pack_instr(fields_s);
  end

`ifdef RANGE_CHECK_EN
  assign err_s = imm_out_of_range(fields_s);
`else
  logic unused_imm_s;
  assign err_s        = 1'b0;
  assign unused_imm_s = ^fields_s.imm[63:32];
`endif

  instr_enc_skid #(.W(33)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({err_s, instr_s}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data_s)
  );

  always_comb begin
    enc_count_d = enc_count_q;
    if (in_valid && in_ready) begin
      enc_count_d = enc_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      enc_count_d = enc_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count_q <= '0;
    end else begin
      enc_count_q <= enc_count_d;
    end
  end

  assign out_instr = out_data_s[31:0];
  assign out_err   = out_data_s[32];
  assign enc_count = enc_count_q;

endmodule
